dds_burst_ctrl: RTL and testbench

- Sequences the serial DDS chip that generates the ultrasound transmit sine.
- On each `start`, loads the DDS over its 3-wire serial interface (`clk_out`/`sync_out`/`din`) with a frequency and a phase word.
- Releases the DDS from reset for a programmed number of clock cycles (the transmit burst), then puts it back into reset.
- Sits between the positioning controller, which issues `start`, and the DDS pins.

---
 rtl/dds_burst_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dds_burst_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_burst_ctrl.sv
// Serial DDS load-and-burst sequencer: frames six control words over a 3-wire
// interface around a programmable-length output-enable burst.
module dds_burst_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [27:0] freq_word,
  input  logic [11:0] phase_word,
  input  logic [15:0] burst_len,
  output logic        busy,
  output logic        burst_active,
  output logic        done,
  output logic        clk_out,
  output logic        sync_out,
  output logic        din
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned FREQ_W  = 28;
  localparam int unsigned PHASE_W = 12;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_PHASE = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_ON    = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_OFF   = IDX_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_BURST,
    S_DONE
  } state_t;

  state_t              state;
  logic [FREQ_W-1:0]   freq_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [LEN_W-1:0]    len_q;
  logic [IDX_W-1:0]    word_idx;
  logic [WORD_W-2:0]   shreg;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    gap_cnt;
  logic [LEN_W-1:0]    burst_cnt;

  logic [IDX_W-1:0]    adv_idx;
  logic                gap_end;
  logic                burst_end;
  logic                load_go;
  logic [WORD_W-1:0]   load_word;

  // Control word for a given slot in the load sequence
  function automatic logic [WORD_W-1:0] word_of(input logic [IDX_W-1:0]   idx,
                                                input logic [FREQ_W-1:0]  f,
                                                input logic [PHASE_W-1:0] p);
    case (idx)
      IDX_W'(0): word_of = 16'h2100;
      IDX_W'(1): word_of = {2'b01, f[13:0]};
      IDX_W'(2): word_of = {2'b01, f[27:14]};
      IDX_W'(3): word_of = {4'hC, p};
      IDX_W'(4): word_of = 16'h2000;
      default:   word_of = 16'h2100;
    endcase
  endfunction

  // Next-word selection; a zero-length burst skips the output-enable word
  always_comb begin
    adv_idx   = (word_idx == IDX_PHASE && len_q == '0) ? IDX_OFF : word_idx + IDX_W'(1);
    gap_end   = (gap_cnt == GAP_LAST);
    burst_end = stop || (burst_cnt == LEN_W'(1));
    load_go   = 1'b0;
    load_word = word_of(word_idx, freq_q, phase_q);
    case (state)
      S_LOAD:  load_go = 1'b1;
      S_GAP: begin
        if (gap_end && word_idx < IDX_ON) begin
          load_go   = 1'b1;
          load_word = word_of(adv_idx, freq_q, phase_q);
        end
      end
      S_BURST: load_go = burst_end;
      default: load_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      freq_q       <= '0;
      phase_q      <= '0;
      len_q        <= '0;
      word_idx     <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      burst_cnt    <= '0;
      busy         <= 1'b0;
      burst_active <= 1'b0;
      done         <= 1'b0;
      clk_out      <= 1'b1;
      sync_out     <= 1'b1;
      din          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load_go) begin
        // Frame start: sync low, first bit presented with clk_out high
        state        <= S_SHIFT;
        sync_out     <= 1'b0;
        clk_out      <= 1'b1;
        din          <= load_word[WORD_W-1];
        shreg        <= load_word[WORD_W-2:0];
        bit_cnt      <= BIT_W'(15);
        div_cnt      <= '0;
        burst_active <= 1'b0;
        if (state == S_GAP) word_idx <= adv_idx;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              freq_q   <= freq_word;
              phase_q  <= phase_word;
              len_q    <= burst_len;
              word_idx <= '0;
              busy     <= 1'b1;
              state    <= S_LOAD;
            end
          end
          S_SHIFT: begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (clk_out) begin
                clk_out <= 1'b0;
              end else if (bit_cnt == '0) begin
                state    <= S_GAP;
                clk_out  <= 1'b1;
                sync_out <= 1'b1;
                din      <= 1'b0;
                gap_cnt  <= '0;
              end else begin
                bit_cnt <= bit_cnt - BIT_W'(1);
                clk_out <= 1'b1;
                din     <= shreg[WORD_W-2];
                shreg   <= {shreg[WORD_W-3:0], 1'b0};
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
          S_GAP: begin
            if (gap_end) begin
              if (word_idx == IDX_ON) begin
                state        <= S_BURST;
                burst_active <= 1'b1;
                burst_cnt    <= len_q;
                word_idx     <= IDX_OFF;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + DIV_W'(1);
            end
          end
          S_BURST: burst_cnt <= burst_cnt - LEN_W'(1);
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_burst_ctrl.sv
// Bench for dds_burst_ctrl: decodes serial frames off the pins and compares
// them, plus burst length and sequence timing, against a word-list model.
module tb_dds_burst_ctrl;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned GAP     = 2;
  localparam int          F       = 32 * CLK_DIV + GAP;
  localparam int          LIMIT   = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [27:0] freq;
  logic [11:0] phase;
  logic [15:0] blen;
  logic        busy, burst_active, done, clk_out, sync_out, din;

  always #5 clk = ~clk;

  dds_burst_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .freq_word(freq), .phase_word(phase), .burst_len(blen),
    .busy(busy), .burst_active(burst_active), .done(done),
    .clk_out(clk_out), .sync_out(sync_out), .din(din)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: the ordered list of words the DDS should receive
  function automatic logic [15:0] exp_word(input int k, input logic [27:0] f,
                                           input logic [11:0] p, input logic [15:0] l);
    logic [15:0] seq[$];
    seq.push_back(16'h2100);
    seq.push_back(16'h4000 | 16'(f[13:0]));
    seq.push_back(16'h4000 | 16'(f[27:14]));
    seq.push_back(16'hC000 | 16'(p));
    if (l != 0) seq.push_back(16'h2000);
    seq.push_back(16'h2100);
    return seq[k];
  endfunction

  function automatic int exp_frames(input logic [15:0] l);
    return (l != 0) ? 6 : 5;
  endfunction

  function automatic int exp_burst(input logic [15:0] l, input int stop_at);
    if (l == 0) return 0;
    if (stop_at != 0 && stop_at < int'(l)) return stop_at;
    return int'(l);
  endfunction

  // Pin-level frame decoder
  logic        mon_clr = 1'b0;
  logic [15:0] mon_words[$];
  int          mon_lows[$];
  int          mon_bits[$];
  int          cur_low = 0, cur_bits = 0, stab_err = 0;
  logic [15:0] cur_word = '0;
  logic        prev_ck = 1'b1, prev_sy = 1'b1, din_hold = 1'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      mon_words.delete(); mon_lows.delete(); mon_bits.delete();
      cur_low = 0; cur_bits = 0; cur_word = '0; stab_err = 0;
    end else if (!sync_out) begin
      cur_low++;
      if (clk_out && (!prev_ck || prev_sy)) din_hold = din;
      else if (din !== din_hold && (clk_out || prev_ck)) stab_err++;
      if (!clk_out && prev_ck) begin
        cur_word = {cur_word[14:0], din};
        cur_bits++;
      end
    end else if (!prev_sy) begin
      mon_words.push_back(cur_word);
      mon_lows.push_back(cur_low);
      mon_bits.push_back(cur_bits);
      cur_low = 0; cur_bits = 0; cur_word = '0;
    end
    prev_ck = clk_out;
    prev_sy = sync_out;
  end

  // One complete sequence from start to done, with all per-run comparisons
  task automatic run_seq(input logic [27:0] f, input logic [11:0] p, input logic [15:0] l,
                         input int stop_at, input bit restart, input bit sid,
                         input int e_frames, input int e_burst, input int e_done);
    int n, busy_low, bact, done_cyc, nf;
    mon_clr = 1'b1;
    @(negedge clk); #1 mon_clr = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
    freq = f; phase = p; blen = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; busy_low = 0; bact = 0; done_cyc = 0;
    while (done_cyc == 0 && n < LIMIT) begin
      if (!busy) busy_low++;
      start = 1'b0;
      if (burst_active) begin
        bact++;
        if (stop_at != 0 && bact == stop_at) stop = 1'b1;
      end else begin
        stop = (stop_at != 0 && n >= 5 && n < 20);
      end
      if (restart && n == 2 + 2 * F + 10) begin
        start = 1'b1;
        freq  = ~f;
      end
      if (done) done_cyc = n + 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0; stop = 1'b0;
    check("done_seen", int'(done_cyc != 0), 1);
    check("done_cycle", done_cyc, e_done);
    check("busy_held", busy_low, 0);
    check("burst_cycles", bact, e_burst);
    check("frame_count", mon_words.size(), e_frames);
    nf = (mon_words.size() < e_frames) ? mon_words.size() : e_frames;
    for (int k = 0; k < nf; k++) begin
      check($sformatf("word%0d", k), int'(mon_words[k]), int'(exp_word(k, f, p, l)));
      check($sformatf("sync_low%0d", k), mon_lows[k], 32 * CLK_DIV);
      check($sformatf("falls%0d", k), mon_bits[k], 16);
    end
    check("din_stable", stab_err, 0);
    if (sid) start = 1'b1;
    @(posedge clk); #1;
    check("done_width", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    if (sid) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("accept_after_done", int'(busy), 1);
    end
  endtask

  typedef struct {
    logic [27:0] f;
    logic [11:0] p;
    logic [15:0] l;
    int          stop_at;
    bit          restart;
    bit          sid;
    int          e_frames;
    int          e_burst;
    int          e_done;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int falls, clkf, guard;
    logic pck, psy;
    logic [27:0] rf;
    logic [11:0] rp;
    logic [15:0] rl;
    int rs;

    tbl[0] = '{28'h0ABCDEF, 12'h123, 16'd100,  0,  1'b0, 1'b0, 6, 100, 499};
    tbl[1] = '{28'h0ABCDEF, 12'h123, 16'd0,    0,  1'b0, 1'b0, 5, 0,   333};
    tbl[2] = '{28'h0ABCDEF, 12'h123, 16'd1000, 10, 1'b0, 1'b0, 6, 10,  409};
    tbl[3] = '{28'h0ABCDEF, 12'h123, 16'd100,  0,  1'b1, 1'b0, 6, 100, 499};
    tbl[4] = '{28'h0ABCDEF, 12'h123, 16'd1,    0,  1'b0, 1'b1, 6, 1,   400};

    rst = 1'b1; start = 1'b0; stop = 1'b0; freq = '0; phase = '0; blen = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_burst", int'(burst_active), 0);
    check("rst_done", int'(done), 0);
    check("rst_clk_out", int'(clk_out), 1);
    check("rst_sync", int'(sync_out), 1);
    check("rst_din", int'(din), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_seq(tbl[i].f, tbl[i].p, tbl[i].l, tbl[i].stop_at, tbl[i].restart, tbl[i].sid,
              tbl[i].e_frames, tbl[i].e_burst, tbl[i].e_done);

    // Last table run left a new sequence running; cut it at bit 7 of W1
    falls = 0; clkf = 0; guard = 0; pck = clk_out; psy = sync_out;
    while (!(clkf == 8 && clk_out) && guard < LIMIT) begin
      @(posedge clk); #1;
      guard++;
      if (psy && !sync_out) falls++;
      if (falls == 2 && pck && !clk_out) clkf++;
      pck = clk_out; psy = sync_out;
    end
    check("reach_w1_bit7", int'(guard < LIMIT), 1);
    check("w1_bit7_din", int'(din), int'(exp_word(1, tbl[4].f, tbl[4].p, tbl[4].l) >> 7) & 1);
    rst = 1'b1;
    #1;
    check("midrst_sync", int'(sync_out), 1);
    check("midrst_clk_out", int'(clk_out), 1);
    check("midrst_din", int'(din), 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk) rst = 1'b0;

    run_seq(28'h0123456, 12'hABC, 16'd20, 0, 1'b0, 1'b0, 6, 20, 3 + 6 * F + 20);

    for (int r = 0; r < 6; r++) begin
      rf = 28'($urandom);
      rp = 12'($urandom);
      rl = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 80));
      rs = (rl > 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rl) - 1)) : 0;
      run_seq(rf, rp, rl, rs, 1'b0, 1'b0, exp_frames(rl), exp_burst(rl, rs),
              3 + exp_frames(rl) * F + exp_burst(rl, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
